// File: rtl/rvsteel_pwm_pkg.sv
// Shared register map and counter width for the rvsteel_pwm bus device.
package rvsteel_pwm_pkg;

    localparam int CNT_W = 16;

    // Word offsets, i.e. rw_address[4:2]
    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_PRESCALE = 3'd1;
    localparam logic [2:0] REG_PERIOD   = 3'd2;
    localparam logic [2:0] REG_COUNTER  = 3'd3;
    localparam logic [2:0] REG_DUTY0    = 3'd4;

    function automatic logic [CNT_W-1:0] merge_lanes(
        input logic [CNT_W-1:0] old_val,
        input logic [CNT_W-1:0] new_val,
        input logic [1:0]       strobe
    );
        merge_lanes = {strobe[1] ? new_val[15:8] : old_val[15:8],
                       strobe[0] ? new_val[7:0]  : old_val[7:0]};
    endfunction

endpackage

// File: rtl/rvsteel_pwm_channel.sv
// One PWM compare channel: double-buffered duty register and registered comparator.
module rvsteel_pwm_channel
    import rvsteel_pwm_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             write_en,
    input  logic [CNT_W-1:0] write_data,
    input  logic [1:0]       write_strobe,
    input  logic             load,
    input  logic             enable,
    input  logic [CNT_W-1:0] counter,
    output logic [CNT_W-1:0] duty_shadow,
    output logic             pwm
);

    logic [CNT_W-1:0] duty_active;

    // load samples the shadow before a same-cycle write lands, so such a
    // write only becomes active at the following period boundary.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            duty_shadow <= '0;
            duty_active <= '0;
            pwm         <= 1'b0;
        end else begin
            if (write_en) duty_shadow <= merge_lanes(duty_shadow, write_data, write_strobe);
            if (load)     duty_active <= duty_shadow;
            pwm <= enable && (counter < duty_active);
        end
    end

endmodule

// File: rtl/rvsteel_pwm.sv
// PWM bus device: shared prescaler and 16-bit period counter driving NUM_CHANNELS outputs.
// Bus: a request held for one cycle yields a one-cycle response pulse the next cycle.
module rvsteel_pwm
    import rvsteel_pwm_pkg::*;
#(
    parameter int NUM_CHANNELS = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4:0]              rw_address,
    output logic [31:0]             read_data,
    input  logic                    read_request,
    output logic                    read_response,
    input  logic [31:0]             write_data,
    input  logic [3:0]              write_strobe,
    input  logic                    write_request,
    output logic                    write_response,
    output logic [NUM_CHANNELS-1:0] pwm_out
);

    logic [2:0]       word;
    logic             en;
    logic [CNT_W-1:0] prescale;
    logic [CNT_W-1:0] pre_cnt;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] period_shadow;
    logic [CNT_W-1:0] period_active;
    logic             tick;
    logic             wrap;
    logic             load;
    logic [31:0]      rdata;
    logic [CNT_W-1:0] duty_shadow [NUM_CHANNELS];

    logic unused_bits;
    assign unused_bits = ^{rw_address[1:0], write_data[31:16], write_strobe[3:2]};

    assign word = rw_address[4:2];
    assign tick = en && (pre_cnt == prescale);
    assign wrap = tick && (counter == period_active);
    // Active copies track the shadows continuously while stopped.
    assign load = !en || wrap;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            en            <= 1'b0;
            prescale      <= '0;
            period_shadow <= '0;
            period_active <= '0;
            pre_cnt       <= '0;
            counter       <= '0;
        end else begin
            if (write_request && word == REG_CTRL && write_strobe[0])
                en <= write_data[0];
            if (write_request && word == REG_PRESCALE)
                prescale <= merge_lanes(prescale, write_data[15:0], write_strobe[1:0]);
            if (write_request && word == REG_PERIOD)
                period_shadow <= merge_lanes(period_shadow, write_data[15:0], write_strobe[1:0]);
            if (load)
                period_active <= period_shadow;

            if (!en) begin
                pre_cnt <= '0;
                counter <= '0;
            end else if (tick) begin
                pre_cnt <= '0;
                counter <= wrap ? '0 : counter + 1'b1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
            rvsteel_pwm_channel u_ch (
                .clock        (clock),
                .reset        (reset),
                .write_en     (write_request && (word == REG_DUTY0 + 3'(i))),
                .write_data   (write_data[15:0]),
                .write_strobe (write_strobe[1:0]),
                .load         (load),
                .enable       (en),
                .counter      (counter),
                .duty_shadow  (duty_shadow[i]),
                .pwm          (pwm_out[i])
            );
        end
    endgenerate

    always_comb begin
        rdata = '0;
        case (word)
            REG_CTRL:     rdata = {31'b0, en};
            REG_PRESCALE: rdata = {16'b0, prescale};
            REG_PERIOD:   rdata = {16'b0, period_shadow};
            REG_COUNTER:  rdata = {16'b0, counter};
            default: begin
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    if (word == REG_DUTY0 + 3'(i)) rdata = {16'b0, duty_shadow[i]};
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            read_data      <= '0;
            read_response  <= 1'b0;
            write_response <= 1'b0;
        end else begin
            read_data      <= read_request ? rdata : '0;
            read_response  <= read_request;
            write_response <= write_request;
        end
    end

endmodule
